// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state encoding, time-field width and preset clamp helper
package countdown_pkg;

  localparam int TIME_W = 6;
  localparam logic [2*TIME_W-1:0] ZERO_TIME = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3
  } state_t;

  // Presets above the field maximum load as the maximum rather than wrapping.
  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// rtl/countdown_ctrl_if.sv - button, preset, counter and display signals of the countdown controller
interface countdown_ctrl_if;
  import countdown_pkg::*;

  logic              tick_1hz;
  logic              btn_start;
  logic              btn_lap;
  logic              btn_clr;
  logic [TIME_W-1:0] preset_min;
  logic [TIME_W-1:0] preset_sec;
  logic [TIME_W-1:0] cnt_min;
  logic [TIME_W-1:0] cnt_sec;
  logic              cnt_en;
  logic              cnt_load;
  logic [TIME_W-1:0] load_min;
  logic [TIME_W-1:0] load_sec;
  logic [TIME_W-1:0] disp_min;
  logic [TIME_W-1:0] disp_sec;
  logic              lap_frz;
  logic              alarm;
  logic [2:0]        state;

  modport master (
    input  tick_1hz, btn_start, btn_lap, btn_clr,
    input  preset_min, preset_sec, cnt_min, cnt_sec,
    output cnt_en, cnt_load, load_min, load_sec,
    output disp_min, disp_sec, lap_frz, alarm, state
  );

  modport slave (
    output tick_1hz, btn_start, btn_lap, btn_clr,
    output preset_min, preset_sec, cnt_min, cnt_sec,
    input  cnt_en, cnt_load, load_min, load_sec,
    input  disp_min, disp_sec, lap_frz, alarm, state
  );

endinterface

// File: rtl/alarm_timer.sv
// rtl/alarm_timer.sv - counts ALARM_TICKS seconds of alarm after the countdown hits zero
module alarm_timer #(
  parameter int ALARM_TICKS = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic tick,
  input  logic clr,
  output logic active,
  output logic expired
);

  localparam logic [3:0] LAST = 4'(ALARM_TICKS - 1);

  logic [3:0] count;

  // Expiry is combinational so the controller can leave DONE on the same edge the alarm drops.
  assign expired = active && tick && !clr && (count == LAST);

  // Alarm window: armed by start, advanced by ticks, aborted by clear.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      active <= 1'b0;
      count  <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
    end else if (active && tick) begin
      if (count == LAST) begin
        active <= 1'b0;
        count  <= '0;
      end else begin
        count <= count + 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - countdown timer control FSM (optional repeat mode: COUNTDOWN_AUTO_RELOAD_EN)
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int SEC_MAX     = 59,
  parameter int MIN_MAX     = 59,
  parameter int ALARM_TICKS = 5
) (
  input logic             clk,
  input logic             rst_n,
  countdown_ctrl_if.master bus
);

  state_t            state_q;
  logic              zero;
  logic              go_done;
  logic              expired;
  logic              lap_nxt;
  logic [TIME_W-1:0] pmin_c;
  logic [TIME_W-1:0] psec_c;

  assign zero    = ({bus.cnt_min, bus.cnt_sec} == ZERO_TIME);
  assign pmin_c  = clamp_time(bus.preset_min, TIME_W'(MIN_MAX));
  assign psec_c  = clamp_time(bus.preset_sec, TIME_W'(SEC_MAX));
  // While cnt_load is high the counter has not yet taken the preset, so its value is stale.
  assign go_done = (state_q == RUN) && !bus.btn_clr && !bus.btn_start && !bus.cnt_load && zero;
  assign bus.state = state_q;

  alarm_timer #(.ALARM_TICKS(ALARM_TICKS)) u_alarm (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (go_done),
    .tick    (bus.tick_1hz && (state_q == DONE)),
    .clr     (bus.btn_clr),
    .active  (bus.alarm),
    .expired (expired)
  );

  // Next lap-freeze value: toggled in RUN, only released in PAUSE, dropped on clear or alarm end.
  always_comb begin
    lap_nxt = bus.lap_frz;
    if (bus.btn_clr) begin
      lap_nxt = 1'b0;
    end else begin
      case (state_q)
        RUN:     if (!bus.btn_start && bus.btn_lap) lap_nxt = !bus.lap_frz;
        PAUSE:   if (!bus.btn_start && bus.btn_lap) lap_nxt = 1'b0;
        DONE:    if (expired) lap_nxt = 1'b0;
        default: lap_nxt = bus.lap_frz;
      endcase
    end
  end

  // Control FSM with registered strobes, load values and display.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bus.cnt_en   <= 1'b0;
      bus.cnt_load <= 1'b1;
      bus.load_min <= pmin_c;
      bus.load_sec <= psec_c;
      bus.disp_min <= '0;
      bus.disp_sec <= '0;
      bus.lap_frz  <= 1'b0;
    end else begin
      bus.cnt_en   <= 1'b0;
      bus.cnt_load <= 1'b0;
      bus.lap_frz  <= lap_nxt;
      if (!bus.lap_frz || !lap_nxt) begin
        bus.disp_min <= bus.cnt_min;
        bus.disp_sec <= bus.cnt_sec;
      end
      if (bus.btn_clr) begin
        state_q      <= IDLE;
        bus.cnt_load <= 1'b1;
        bus.load_min <= pmin_c;
        bus.load_sec <= psec_c;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.btn_start && !bus.cnt_load && !zero) state_q <= RUN;
          end
          RUN: begin
            if (bus.btn_start) begin
              state_q <= PAUSE;
            end else if (!bus.cnt_load) begin
              if (zero) state_q <= DONE;
              else if (!bus.btn_lap && bus.tick_1hz) bus.cnt_en <= 1'b1;
            end
          end
          PAUSE: begin
            if (bus.btn_start) state_q <= RUN;
          end
          DONE: begin
            if (expired) begin
              bus.cnt_load <= 1'b1;
              bus.load_min <= pmin_c;
              bus.load_sec <= psec_c;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              state_q <= ({pmin_c, psec_c} == ZERO_TIME) ? IDLE : RUN;
`else
              state_q <= IDLE;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed self-checking bench for countdown_ctrl with a min/sec counter model
module tb_countdown_ctrl;

  localparam logic [3:0] M_CLR   = 4'b1000;
  localparam logic [3:0] M_START = 4'b0100;
  localparam logic [3:0] M_LAP   = 4'b0010;
  localparam logic [3:0] M_TICK  = 4'b0001;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam int ST_AFTER_ALARM = 1;
`else
  localparam int ST_AFTER_ALARM = 0;
`endif

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   en_cnt;

  countdown_ctrl_if bus ();

  countdown_ctrl #(.SEC_MAX(59), .MIN_MAX(59), .ALARM_TICKS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External min/sec counter: load has priority, decrement borrows from minutes.
  always @(posedge clk) begin
    if (bus.cnt_load) begin
      bus.cnt_min <= bus.load_min;
      bus.cnt_sec <= bus.load_sec;
    end else if (bus.cnt_en) begin
      if (bus.cnt_sec == 6'd0) begin
        bus.cnt_sec <= 6'd59;
        bus.cnt_min <= bus.cnt_min - 6'd1;
      end else begin
        bus.cnt_sec <= bus.cnt_sec - 6'd1;
      end
    end
  end

  // Count decrement strobes (value seen at the edge is the previous cycle's).
  always @(posedge clk) begin
    if (bus.cnt_en) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    {bus.btn_clr, bus.btn_start, bus.btn_lap, bus.tick_1hz} = m;
    @(negedge clk);
    {bus.btn_clr, bus.btn_start, bus.btn_lap, bus.tick_1hz} = 4'b0000;
  endtask

  task automatic wait_state(input int s, input string tag);
    int n;
    n = 0;
    while (int'(bus.state) != s && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(bus.state), s);
  endtask

  task automatic load_preset(input logic [5:0] m, input logic [5:0] s);
    bus.preset_min = m;
    bus.preset_sec = s;
    pulse(M_CLR);
    cyc(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    en_cnt = 0;
    rst_n = 1'b0;
    {bus.btn_clr, bus.btn_start, bus.btn_lap, bus.tick_1hz} = 4'b0000;
    bus.preset_min = 6'd0;
    bus.preset_sec = 6'd3;

    // Reset values
    cyc(2);
    check("rst_state", int'(bus.state), 0);
    check("rst_alarm", int'(bus.alarm), 0);
    check("rst_lap", int'(bus.lap_frz), 0);
    check("rst_en", int'(bus.cnt_en), 0);
    check("rst_load", int'(bus.cnt_load), 1);
    check("rst_load_sec", int'(bus.load_sec), 3);
    check("rst_disp", int'({bus.disp_min, bus.disp_sec}), 0);
    rst_n = 1'b1;
    cyc(1);
    check("rst_load_once", int'(bus.cnt_load), 0);
    check("rst_cnt_sec", int'(bus.cnt_sec), 3);

    // Full countdown from 00:03 and alarm
    cyc(1);
    en_cnt = 0;
    pulse(M_START);
    check("t1_run", int'(bus.state), 1);
    for (int i = 0; i < 3; i++) begin
      pulse(M_TICK);
      cyc(3);
    end
    wait_state(3, "t1_done");
    check("t1_en_pulses", en_cnt, 3);
    check("t1_cnt_zero", int'({bus.cnt_min, bus.cnt_sec}), 0);
    check("t1_alarm_on", int'(bus.alarm), 1);
    for (int i = 0; i < 4; i++) begin
      pulse(M_TICK);
      cyc(2);
    end
    check("t1_alarm_4", int'(bus.alarm), 1);
    check("t1_done_4", int'(bus.state), 3);
    pulse(M_TICK);
    check("t1_alarm_off", int'(bus.alarm), 0);
    check("t1_after_state", int'(bus.state), ST_AFTER_ALARM);
    check("t1_reload", int'(bus.cnt_load), 1);
    check("t1_load_sec", int'(bus.load_sec), 3);
    cyc(1);
    check("t1_reload_once", int'(bus.cnt_load), 0);
    check("t1_no_en_alarm", en_cnt, 3);

    // Pause with simultaneous tick at 01:10
    load_preset(6'd1, 6'd10);
    en_cnt = 0;
    pulse(M_START);
    check("t2_run", int'(bus.state), 1);
    cyc(2);
    pulse(M_START | M_TICK);
    check("t2_pause", int'(bus.state), 2);
    check("t2_no_en", int'(bus.cnt_en), 0);
    cyc(2);
    pulse(M_TICK);
    cyc(2);
    pulse(M_TICK);
    cyc(2);
    check("t2_paused_en", en_cnt, 0);
    check("t2_hold", int'({bus.cnt_min, bus.cnt_sec}), (1 << 6) | 10);
    pulse(M_START);
    check("t2_resume", int'(bus.state), 1);
    pulse(M_TICK);
    cyc(2);
    check("t2_dec", int'({bus.cnt_min, bus.cnt_sec}), (1 << 6) | 9);

    // Lap freeze at 00:45
    load_preset(6'd0, 6'd45);
    pulse(M_START);
    cyc(2);
    pulse(M_LAP);
    check("t3_frz", int'(bus.lap_frz), 1);
    check("t3_disp_cap", int'({bus.disp_min, bus.disp_sec}), 45);
    for (int i = 0; i < 5; i++) begin
      pulse(M_TICK);
      cyc(2);
    end
    check("t3_cnt", int'(bus.cnt_sec), 40);
    check("t3_disp_held", int'(bus.disp_sec), 45);
    pulse(M_LAP);
    check("t3_unfrz", int'(bus.lap_frz), 0);
    check("t3_disp_follow", int'(bus.disp_sec), 40);

    // Zero preset and clamping
    load_preset(6'd0, 6'd0);
    en_cnt = 0;
    pulse(M_START);
    cyc(1);
    check("t4_zero_idle", int'(bus.state), 0);
    pulse(M_TICK);
    cyc(2);
    check("t4_zero_en", en_cnt, 0);
    check("t4_zero_load", int'(bus.cnt_load), 0);
    bus.preset_min = 6'd63;
    bus.preset_sec = 6'd62;
    pulse(M_CLR);
    check("t4_clamp_load", int'(bus.cnt_load), 1);
    check("t4_clamp_min", int'(bus.load_min), 59);
    check("t4_clamp_sec", int'(bus.load_sec), 59);
    bus.preset_min = 6'd59;
    bus.preset_sec = 6'd58;
    pulse(M_CLR);
    check("t4_edge_min", int'(bus.load_min), 59);
    check("t4_edge_sec", int'(bus.load_sec), 58);

    // Clear during alarm, then reset during RUN
    load_preset(6'd0, 6'd1);
    pulse(M_START);
    cyc(2);
    pulse(M_TICK);
    wait_state(3, "t5_done");
    check("t5_alarm", int'(bus.alarm), 1);
    pulse(M_TICK);
    cyc(1);
    pulse(M_CLR);
    check("t5_clr_alarm", int'(bus.alarm), 0);
    check("t5_clr_state", int'(bus.state), 0);
    check("t5_clr_load", int'(bus.cnt_load), 1);
    load_preset(6'd0, 6'd5);
    pulse(M_START);
    cyc(2);
    pulse(M_LAP);
    check("t5_pre_frz", int'(bus.lap_frz), 1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.tick_1hz = 1'b1;
    @(negedge clk);
    bus.tick_1hz = 1'b0;
    check("t5_rst_state", int'(bus.state), 0);
    check("t5_rst_alarm", int'(bus.alarm), 0);
    check("t5_rst_lap", int'(bus.lap_frz), 0);
    check("t5_rst_en", int'(bus.cnt_en), 0);
    check("t5_rst_load", int'(bus.cnt_load), 1);
    check("t5_rst_disp", int'({bus.disp_min, bus.disp_sec}), 0);
    rst_n = 1'b1;
    cyc(2);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Repeating timer from 00:02
    load_preset(6'd0, 6'd2);
    pulse(M_START);
    for (int r = 0; r < 2; r++) begin
      cyc(2);
      for (int i = 0; i < 2; i++) begin
        pulse(M_TICK);
        cyc(3);
      end
      wait_state(3, "t6_done");
      check("t6_alarm", int'(bus.alarm), 1);
      for (int i = 0; i < 5; i++) pulse(M_TICK);
      check("t6_rerun", int'(bus.state), 1);
      check("t6_reload", int'(bus.cnt_load), 1);
      check("t6_alarm_off", int'(bus.alarm), 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
